// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source identifiers and the buffered result record for the CDB arbiter.
package cdb_arbiter_pkg;
   localparam int PRF_ADDR_WIDTH = 6;
   localparam int PRF_WIDTH      = 32;
   localparam int ROB_ADDR_WIDTH = 5;

   localparam logic [1:0] SRC_INT  = 2'd0;
   localparam logic [1:0] SRC_MULT = 2'd1;
   localparam logic [1:0] SRC_DIV  = 2'd2;
   localparam logic [1:0] SRC_LSQ  = 2'd3;

   typedef struct packed {
      logic [PRF_ADDR_WIDTH-1:0] tag;
      logic [PRF_WIDTH-1:0]      data;
      logic [ROB_ADDR_WIDTH-1:0] rob;
   } cdb_entry_t;
endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer: push/pop the same cycle at any count, clear empties it next edge.
// Full is decoded from the registered count, so it never anticipates a same-cycle pop.
module cdb_src_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: four buffered result sources, one registered broadcast per cycle.
// Optional CDB_BYPASS_EN lets a lone valid source with all buffers empty skip its FIFO.
module cdb_arbiter #(
   parameter int PRF_ADDR_WIDTH = cdb_arbiter_pkg::PRF_ADDR_WIDTH,
   parameter int PRF_WIDTH      = cdb_arbiter_pkg::PRF_WIDTH,
   parameter int ROB_ADDR_WIDTH = cdb_arbiter_pkg::ROB_ADDR_WIDTH,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      int_valid,
   input  logic                      mult_valid,
   input  logic                      div_valid,
   input  logic                      lsq_valid,
   output logic                      int_ready,
   output logic                      mult_ready,
   output logic                      div_ready,
   output logic                      lsq_ready,
   input  logic [PRF_ADDR_WIDTH-1:0] int_tag,
   input  logic [PRF_ADDR_WIDTH-1:0] mult_tag,
   input  logic [PRF_ADDR_WIDTH-1:0] div_tag,
   input  logic [PRF_ADDR_WIDTH-1:0] lsq_tag,
   input  logic [PRF_WIDTH-1:0]      int_data,
   input  logic [PRF_WIDTH-1:0]      mult_data,
   input  logic [PRF_WIDTH-1:0]      div_data,
   input  logic [PRF_WIDTH-1:0]      lsq_data,
   input  logic [ROB_ADDR_WIDTH-1:0] int_rob,
   input  logic [ROB_ADDR_WIDTH-1:0] mult_rob,
   input  logic [ROB_ADDR_WIDTH-1:0] div_rob,
   input  logic [ROB_ADDR_WIDTH-1:0] lsq_rob,
   output logic                      cdb_w_en,
   output logic [PRF_ADDR_WIDTH-1:0] cdb_w_addr,
   output logic [PRF_WIDTH-1:0]      cdb_din,
   output logic [ROB_ADDR_WIDTH-1:0] cdb_rob_tag,
   output logic [1:0]                cdb_src
);
   localparam int EW = PRF_ADDR_WIDTH + PRF_WIDTH + ROB_ADDR_WIDTH;

   logic [3:0]    valid_v, full, empty, push, pop, cand;
   logic [EW-1:0] in_ent [4];
   logic [EW-1:0] head   [4];
   logic [1:0]    rr_ptr, gnt_idx, idx, byp_idx, src_n;
   logic          gnt_vld, byp, fire;
   logic [EW-1:0] sel;

   assign valid_v = {lsq_valid, div_valid, mult_valid, int_valid};
   assign in_ent[cdb_arbiter_pkg::SRC_INT]  = {int_tag,  int_data,  int_rob};
   assign in_ent[cdb_arbiter_pkg::SRC_MULT] = {mult_tag, mult_data, mult_rob};
   assign in_ent[cdb_arbiter_pkg::SRC_DIV]  = {div_tag,  div_data,  div_rob};
   assign in_ent[cdb_arbiter_pkg::SRC_LSQ]  = {lsq_tag,  lsq_data,  lsq_rob};

   assign int_ready  = ~full[cdb_arbiter_pkg::SRC_INT];
   assign mult_ready = ~full[cdb_arbiter_pkg::SRC_MULT];
   assign div_ready  = ~full[cdb_arbiter_pkg::SRC_DIV];
   assign lsq_ready  = ~full[cdb_arbiter_pkg::SRC_LSQ];

   assign cand = ~empty;

   // Scan offsets high to low so the nearest non-empty source from rr_ptr wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = rr_ptr;
      idx     = '0;
      for (int i = 3; i >= 0; i--) begin
         idx = rr_ptr + 2'(i);
         if (cand[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

`ifdef CDB_BYPASS_EN
   always_comb begin
      byp_idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (valid_v[i]) byp_idx = 2'(i);
      end
   end
   assign byp = ~|cand & ~flush & (valid_v != '0) & ((valid_v & (valid_v - 4'd1)) == '0);
`else
   assign byp_idx = '0;
   assign byp     = 1'b0;
`endif

   assign sel   = byp ? in_ent[byp_idx] : head[gnt_idx];
   assign src_n = byp ? byp_idx : gnt_idx;
   assign fire  = (gnt_vld | byp) & ~flush;

   for (genvar g = 0; g < 4; g++) begin : g_src
      assign push[g] = valid_v[g] & ~full[g] & ~(byp && (byp_idx == 2'(g)));
      assign pop[g]  = gnt_vld & ~flush & (gnt_idx == 2'(g));

      cdb_src_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (EW)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .clear     (flush),
         .push      (push[g]),
         .push_data (in_ent[g]),
         .pop       (pop[g]),
         .full      (full[g]),
         .empty     (empty[g]),
         .head      (head[g])
      );
   end

   // Payload registers hold their last broadcast when idle; only w_en drops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdb_w_en    <= 1'b0;
         cdb_w_addr  <= '0;
         cdb_din     <= '0;
         cdb_rob_tag <= '0;
         cdb_src     <= '0;
         rr_ptr      <= '0;
      end else begin
         cdb_w_en <= fire;
         if (fire) begin
            cdb_w_addr  <= sel[EW-1 -: PRF_ADDR_WIDTH];
            cdb_din     <= sel[ROB_ADDR_WIDTH +: PRF_WIDTH];
            cdb_rob_tag <= sel[ROB_ADDR_WIDTH-1:0];
            cdb_src     <= src_n;
            rr_ptr      <= src_n + 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin, backpressure, flush, PRF fill.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

`ifdef CDB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        reset, flush;
   logic [3:0]  v;
   logic [3:0]  rdy;
   logic [5:0]  tg [4];
   logic [31:0] dt [4];
   logic [4:0]  rb [4];
   logic        cdb_w_en;
   logic [5:0]  cdb_w_addr;
   logic [31:0] cdb_din;
   logic [4:0]  cdb_rob_tag;
   logic [1:0]  cdb_src;

   cdb_arbiter dut (
      .clk(clk), .reset(reset), .flush(flush),
      .int_valid(v[0]), .mult_valid(v[1]), .div_valid(v[2]), .lsq_valid(v[3]),
      .int_ready(rdy[0]), .mult_ready(rdy[1]), .div_ready(rdy[2]), .lsq_ready(rdy[3]),
      .int_tag(tg[0]), .mult_tag(tg[1]), .div_tag(tg[2]), .lsq_tag(tg[3]),
      .int_data(dt[0]), .mult_data(dt[1]), .div_data(dt[2]), .lsq_data(dt[3]),
      .int_rob(rb[0]), .mult_rob(rb[1]), .div_rob(rb[2]), .lsq_rob(rb[3]),
      .cdb_w_en(cdb_w_en), .cdb_w_addr(cdb_w_addr), .cdb_din(cdb_din),
      .cdb_rob_tag(cdb_rob_tag), .cdb_src(cdb_src)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   int          remaining [4];
   int          seq       [4];
   int          pushes    [4];
   logic [31:0] dbase     [4];
   logic [5:0]  tbase     [4];
   logic [4:0]  rbase     [4];
   logic [3:0]  rdy_low_seen;
   logic        held_seen;
   int          log_src [$];
   logic [31:0] log_din [$];
   logic [31:0] prf [48];

   // Source model: present next payload while work remains, advance only on valid & ready.
   task automatic cyc();
      logic [3:0] rp;
      for (int s = 0; s < 4; s++) begin
         v[s]  = (remaining[s] > 0);
         tg[s] = tbase[s] + 6'(seq[s]);
         dt[s] = dbase[s] + 32'(seq[s]);
         rb[s] = rbase[s] + 5'(seq[s]);
      end
      rp = rdy;
      if (v[2] && !rp[2]) held_seen = 1'b1;
      @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) begin
         if (v[s] && rp[s]) begin
            seq[s]++;
            remaining[s]--;
            pushes[s]++;
         end
      end
      rdy_low_seen |= ~rdy;
      if (cdb_w_en) begin
         log_src.push_back(int'(cdb_src));
         log_din.push_back(cdb_din);
         if (cdb_w_addr < 6'd48) prf[cdb_w_addr] = cdb_din;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      flush = 1'b0;
      v     = '0;
      for (int s = 0; s < 4; s++) begin
         remaining[s] = 0; seq[s] = 0; pushes[s] = 0;
         dbase[s] = '0; tbase[s] = '0; rbase[s] = '0;
         tg[s] = '0; dt[s] = '0; rb[s] = '0;
      end
      rdy_low_seen = '0;
      held_seen    = 1'b0;
      log_src.delete();
      log_din.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b0;
      #1;
      n_checks++;
      if ({cdb_w_en, cdb_w_addr, cdb_din, cdb_rob_tag, cdb_src, rdy} !== {1'b0, 6'd0, 32'd0, 5'd0, 2'd0, 4'hf})
         $display("FAIL reset_state: got w_en=%b addr=%0d din=%0d rob=%0d src=%0d rdy=%b, want 0/0/0/0/0/1111",
                  cdb_w_en, cdb_w_addr, cdb_din, cdb_rob_tag, cdb_src, rdy);
      else n_pass++;
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cyc();
         n_checks++;
         if ({cdb_w_en, rdy} !== 5'b0_1111)
            $display("FAIL idle_cycle%0d: got w_en=%b rdy=%b, want 0 1111", c, cdb_w_en, rdy);
         else n_pass++;
      end
   endtask

   task automatic test_single();
      do_reset();
      tbase[0] = 6'd5; dbase[0] = 32'd1005; rbase[0] = 5'd3; remaining[0] = 1;
      for (int c = 1; c <= 3; c++) begin
         cyc();
         n_checks++;
         if (c == LAT) begin
            if ({cdb_w_en, cdb_w_addr, cdb_din, cdb_rob_tag, cdb_src} !== {1'b1, 6'd5, 32'd1005, 5'd3, 2'd0})
               $display("FAIL single_bcast: got w_en=%b addr=%0d din=%0d rob=%0d src=%0d, want 1/5/1005/3/0",
                        cdb_w_en, cdb_w_addr, cdb_din, cdb_rob_tag, cdb_src);
            else n_pass++;
         end else begin
            if (cdb_w_en !== 1'b0)
               $display("FAIL single_idle_edge%0d: got w_en=%b, want 0", c, cdb_w_en);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      int c;
      do_reset();
      tbase[0] = 6'd9; dbase[0] = 32'd77; rbase[0] = 5'd1; remaining[0] = 1;
      c = 0;
      while (!cdb_w_en && c < 5) begin
         cyc();
         c++;
      end
      n_checks++;
      if (cdb_w_en !== 1'b1) $display("FAIL reset_mid_setup: got w_en=%b, want 1 within 5 cycles", cdb_w_en);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({cdb_w_en, cdb_din} !== {1'b0, 32'd0})
         $display("FAIL reset_mid_async: got w_en=%b din=%0d, want 0 0 before next edge", cdb_w_en, cdb_din);
      else n_pass++;
      reset = 1'b1;
   endtask

   task automatic test_round_robin();
      int c;
      do_reset();
      for (int s = 0; s < 4; s++) begin
         dbase[s] = 32'(2000 + 100 * s);
         tbase[s] = 6'(10 * s);
         remaining[s] = 1000;
      end
      c = 0;
      while (log_src.size() < 16 && c < 40) begin
         cyc();
         c++;
      end
      n_checks++;
      if (log_src.size() < 16) $display("FAIL rr_timeout: got %0d broadcasts, want 16", log_src.size());
      else begin
         n_pass++;
         for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (log_src[k] != k % 4 || log_din[k] !== 32'(2000 + 100 * (k % 4) + k / 4))
               $display("FAIL rr_slot%0d: got src=%0d din=%0d, want src=%0d din=%0d",
                        k, log_src[k], log_din[k], k % 4, 2000 + 100 * (k % 4) + k / 4);
            else n_pass++;
         end
      end
      n_checks++;
      if (rdy_low_seen !== 4'hf) $display("FAIL rr_ready_toggle: got low_seen=%b, want 1111", rdy_low_seen);
      else n_pass++;
      for (int s = 0; s < 4; s++) remaining[s] = 0;
   endtask

   task automatic test_backpressure();
      logic        checked;
      logic [31:0] div_d [$];
      do_reset();
      for (int s = 0; s < 4; s++) begin
         dbase[s] = 32'(3000 + 100 * s);
         remaining[s] = 1000;
      end
      dbase[2] = 32'd1100;
      remaining[2] = 3;
      checked = 1'b0;
      for (int c = 0; c < 30; c++) begin
         cyc();
         if (pushes[2] == 2 && !checked) begin
            checked = 1'b1;
            n_checks++;
            if (rdy[2] !== 1'b0) $display("FAIL bp_div_ready: got %b after 2 pushes, want 0", rdy[2]);
            else n_pass++;
         end
      end
      for (int s = 0; s < 4; s++) remaining[s] = 0;
      repeat (12) cyc();
      n_checks++;
      if (pushes[2] != 3 || held_seen !== 1'b1)
         $display("FAIL bp_div_accept: got pushes=%0d held=%b, want 3 1", pushes[2], held_seen);
      else n_pass++;
      for (int k = 0; k < log_src.size(); k++) if (log_src[k] == 2) div_d.push_back(log_din[k]);
      n_checks++;
      if (div_d.size() != 3) $display("FAIL bp_div_count: got %0d div broadcasts, want 3", div_d.size());
      else begin
         n_pass++;
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (div_d[k] !== 32'(1100 + k))
               $display("FAIL bp_div_order%0d: got %0d, want %0d", k, div_d[k], 1100 + k);
            else n_pass++;
         end
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int s = 0; s < 4; s++) begin
         dbase[s] = 32'(4000 + 100 * s);
         remaining[s] = 1000;
      end
      repeat (3) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      n_checks++;
      if ({cdb_w_en, rdy} !== 5'b0_1111)
         $display("FAIL flush_edge: got w_en=%b rdy=%b, want 0 1111", cdb_w_en, rdy);
      else n_pass++;
      for (int s = 0; s < 4; s++) remaining[s] = 0;
      for (int c = 0; c < 5; c++) begin
         cyc();
         n_checks++;
         if (cdb_w_en !== 1'b0)
            $display("FAIL flush_after%0d: got w_en=%b din=%0d, want w_en 0", c, cdb_w_en, cdb_din);
         else n_pass++;
      end
   endtask

   task automatic test_prf();
      int c;
      do_reset();
      for (int i = 0; i < 48; i++) prf[i] = '0;
      tbase[3] = 6'd0; dbase[3] = 32'd1000; rbase[3] = 5'd0; remaining[3] = 48;
      c = 0;
      while (pushes[3] < 48 && c < 100) begin
         cyc();
         c++;
      end
      repeat (4) cyc();
      for (int i = 0; i < 48; i++) begin
         n_checks++;
         if (prf[i] !== 32'(1000 + i)) $display("FAIL prf_tag%0d: got %0d, want %0d", i, prf[i], 1000 + i);
         else n_pass++;
      end
   endtask

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      v     = '0;
      test_reset();
      test_single();
      test_reset_mid();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_prf();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
